line_buffer_ctrl: RTL and testbench
===================================

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 SHALL have parameter FILTER_SIZE, default -1 (must be overridden), window edge length; legal range 2..IMAGE_SIZE-1.
REQ-002 SHALL have parameter IMAGE_SIZE, default -1 (must be overridden), square image edge length in pixels.
REQ-003 SHALL have parameter D_WIDTH, default -1 (must be overridden), pixel width in bits.
REQ-004 SHALL define AW = `LOG2(IMAGE_SIZE), DEPTH = IMAGE_SIZE-(FILTER_SIZE-1), WW = D_WIDTH*FILTER_SIZE*FILTER_SIZE.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  upstream pixel valid.
REQ-008 in_ready  out  1  block can accept a pixel this cycle.
REQ-009 in_data  in  D_WIDTH  raster-order pixel.
REQ-010 lb_clk_en  out  1  line-buffer advance enable.
REQ-011 lb_wr_addr  out  AW  line-buffer RAM write address.
REQ-012 lb_rd_addr  out  AW  line-buffer RAM read address.
REQ-013 lb_in_data  out  D_WIDTH  pixel to line buffer (equals in_data).
REQ-014 lb_window  in  WW  window bus returned by the line buffer (row i at slice i*FILTER_SIZE*D_WIDTH, oldest row i=0, oldest column lowest).
REQ-015 out_valid  out  1  out_window holds a valid window.
REQ-016 out_ready  in  1  downstream accepts the window.
REQ-017 out_window  out  WW  registered window, same layout as lb_window.
REQ-018 out_last  out  1  out_window is the last window of the frame.
REQ-019 frame_done  out  1  one-cycle pulse after the final pixel of a frame is accepted.

Function
REQ-020 in_ready SHALL equal (!out_valid || out_ready) and SHALL be 0 while rst is high.
REQ-021 accept = in_valid && in_ready; lb_clk_en SHALL equal accept combinationally.
REQ-022 wr pointer SHALL advance 0,1,..,DEPTH-1,0 on each accept; lb_wr_addr = pointer.
REQ-023 lb_rd_addr SHALL equal (pointer+1) mod DEPTH at all times (synchronous-read RAM gives DEPTH-cycle delay, total row delay IMAGE_SIZE).
REQ-024 col counter SHALL advance 0..IMAGE_SIZE-1 on accept and wrap to 0, incrementing row counter; row wraps IMAGE_SIZE-1 -> 0.
REQ-025 FSM states: FILL (row < FILTER_SIZE-1) and STREAM; FILL->STREAM on accept of pixel (FILTER_SIZE-2, IMAGE_SIZE-1); STREAM->FILL on accept of pixel (IMAGE_SIZE-1, IMAGE_SIZE-1).
REQ-026 win_hit = accept && state==STREAM && col >= FILTER_SIZE-1, evaluated on the pixel being accepted.
REQ-027 On win_hit: out_window <= lb_window, out_valid <= 1, out_last <= (row==IMAGE_SIZE-1 && col==IMAGE_SIZE-1); latency one cycle from accept.
REQ-028 Without win_hit: out_valid SHALL clear when out_ready is 1, else hold out_valid/out_window/out_last unchanged.
REQ-029 Held output SHALL never be overwritten: accept is impossible while out_valid && !out_ready.
REQ-030 frame_done SHALL be 1 exactly the cycle after accept of pixel (IMAGE_SIZE-1, IMAGE_SIZE-1), else 0.
REQ-031 Windows per frame SHALL be (IMAGE_SIZE-FILTER_SIZE+1)^2; back-to-back frames need no idle cycle; stale line-buffer contents are masked by FILL/col gating.
REQ-032 in_valid low SHALL freeze pointer, counters, FSM and line buffer (lb_clk_en 0).

Reset
REQ-033 On rst: pointer 0, lb_rd_addr 1 mod DEPTH, row 0, col 0, state FILL, out_valid 0, out_window 0, out_last 0, frame_done 0.
REQ-034 rst mid-frame SHALL abandon the frame; next accepted pixel is treated as (0,0); no window emitted until row FILTER_SIZE-1, col FILTER_SIZE-1 of the new frame.

Verification (FILTER_SIZE=3, IMAGE_SIZE=8, D_WIDTH=8, pixel value = row*8+col)
REQ-035 Continuous stream, out_ready=1 -> first out_valid the cycle after pixel 18 accepted, out_window slots 0..8 = {0,1,2,8,9,10,16,17,18}; 36 windows per frame.
REQ-036 Address wrap -> lb_wr_addr sequence 0..5,0; lb_rd_addr always wr+1 mod 6 (5 -> 0).
REQ-037 out_ready=0 while window 18 held -> in_ready=0, lb_clk_en=0, out_window stable; release -> stream resumes with no loss.
REQ-038 Two frames back-to-back -> out_last with window ending pixel 63, frame_done pulse next cycle, second frame's first window again {0,1,2,8,9,10,16,17,18}.
REQ-039 rst asserted after pixel 30 accepted -> outputs reset per REQ-033; restarted frame yields first window after its pixel 18.
REQ-040 Random in_valid gaps -> window sequence identical to REQ-035.

Source files
------------

// File: rtl/line_buffer_ctrl_if.sv
// Pixel-stream, line-buffer RAM and window-output signals
// of the sliding-window line buffer controller.
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

interface line_buffer_ctrl_if #(
  parameter int FILTER_SIZE = -1,
  parameter int IMAGE_SIZE  = -1,
  parameter int D_WIDTH     = -1
);
  localparam int AW = `LOG2(IMAGE_SIZE);
  localparam int WW = D_WIDTH*FILTER_SIZE*FILTER_SIZE;

  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] in_data;
  logic               lb_clk_en;
  logic [AW-1:0]      lb_wr_addr;
  logic [AW-1:0]      lb_rd_addr;
  logic [D_WIDTH-1:0] lb_in_data;
  logic [WW-1:0]      lb_window;
  logic               out_valid;
  logic               out_ready;
  logic [WW-1:0]      out_window;
  logic               out_last;
  logic               frame_done;

  modport slave (
    input  in_valid, in_data, lb_window, out_ready,
    output in_ready, lb_clk_en, lb_wr_addr, lb_rd_addr,
    output lb_in_data, out_valid, out_window, out_last,
    output frame_done
  );

  modport master (
    output in_valid, in_data, lb_window, out_ready,
    input  in_ready, lb_clk_en, lb_wr_addr, lb_rd_addr,
    input  lb_in_data, out_valid, out_window, out_last,
    input  frame_done
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: RAM addressing, raster tracking and
// registered window output with valid/ready backpressure.
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif

module line_buffer_ctrl #(
  parameter int FILTER_SIZE = -1,
  parameter int IMAGE_SIZE  = -1,
  parameter int D_WIDTH     = -1
) (
  input  logic               clk,
  input  logic               rst,
  line_buffer_ctrl_if.slave  bus
);
  localparam int AW    = `LOG2(IMAGE_SIZE);
  localparam int DEPTH = IMAGE_SIZE-(FILTER_SIZE-1);
  localparam int WW    = D_WIDTH*FILTER_SIZE*FILTER_SIZE;

  localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH-1);
  localparam logic [AW-1:0] N_MAX    = AW'(IMAGE_SIZE-1);
  localparam logic [AW-1:0] F_EDGE   = AW'(FILTER_SIZE-1);
  localparam logic [AW-1:0] FILL_ROW = AW'(FILTER_SIZE-2);

  typedef enum logic {FILL, STREAM} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, r_row, r_col;
  logic          r_out_valid, r_out_last, r_frame_done;
  logic [WW-1:0] r_out_window;

  logic w_ready, w_accept, w_col_end, w_row_end;
  logic w_frame_end, w_win_hit;

  assign w_ready     = !rst && (!r_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_ready;
  assign w_col_end   = (r_col == N_MAX);
  assign w_row_end   = (r_row == N_MAX);
  assign w_frame_end = w_accept && w_col_end && w_row_end;
  assign w_win_hit   = w_accept && (r_state == STREAM)
                     && (r_col >= F_EDGE);

  assign bus.in_ready   = w_ready;
  assign bus.lb_clk_en  = w_accept;
  assign bus.lb_wr_addr = r_ptr;
  // Read one slot ahead so the sync-read RAM yields a full row delay
  assign bus.lb_rd_addr = (r_ptr == PTR_MAX) ? '0 : r_ptr + 1'b1;
  assign bus.lb_in_data = bus.in_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_window = r_out_window;
  assign bus.out_last   = r_out_last;
  assign bus.frame_done = r_frame_done;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL:
        if (w_accept && r_row == FILL_ROW && w_col_end)
          w_state_nxt = STREAM;
      STREAM:
        if (w_frame_end)
          w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      r_ptr <= (r_ptr == PTR_MAX) ? '0 : r_ptr + 1'b1;
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_win_hit) begin
        r_out_valid  <= 1'b1;
        r_out_window <= bus.lb_window;
        r_out_last   <= w_col_end && w_row_end;
      end else if (bus.out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with a behavioural line buffer
// and a window scoreboard.
module tb_line_buffer_ctrl;
  localparam int F     = 3;
  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int WW    = DW*F*F;
  localparam int DEPTH = N-(F-1);
  localparam int HL    = (F-1)*N+(F-1);

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buffer_ctrl_if #(
    .FILTER_SIZE(F), .IMAGE_SIZE(N), .D_WIDTH(DW)
  ) bus ();

  line_buffer_ctrl #(
    .FILTER_SIZE(F), .IMAGE_SIZE(N), .D_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [DW-1:0] hist [HL];

  always @(posedge clk) begin
    if (bus.lb_clk_en) begin
      for (int k = HL-1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= bus.in_data;
    end
  end

  always_comb begin
    bus.lb_window = '0;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < F; j++) begin
        int k;
        k = (F-1-i)*N + (F-1-j);
        if (k == 0)
          bus.lb_window[(i*F+j)*DW +: DW] = bus.in_data;
        else
          bus.lb_window[(i*F+j)*DW +: DW] = hist[k-1];
      end
  end

  exp_t sb[$];
  int checks, errors;
  int tr, tc, ptr_m, cyc, accepts, wins, lasts;
  int first_cyc;
  bit first_checked, fd_exp;

  task automatic step(input bit v, input bit ordy);
    bit exp_rdy, acc, fdn;
    exp_t e, g;
    @(negedge clk);
    cyc++;
    checks++;
    if (bus.frame_done !== fd_exp) begin
      errors++;
      $display("FAIL frame_done got %0b exp %0b", bus.frame_done, fd_exp);
    end
    checks++;
    if (bus.lb_wr_addr !== 3'(ptr_m)) begin
      errors++;
      $display("FAIL wr_addr got %0d exp %0d", bus.lb_wr_addr, ptr_m);
    end
    checks++;
    if (bus.lb_rd_addr !== 3'((ptr_m+1)%DEPTH)) begin
      errors++;
      $display("FAIL rd_addr got %0d exp %0d",
               bus.lb_rd_addr, (ptr_m+1)%DEPTH);
    end
    bus.in_valid  = v;
    bus.out_ready = ordy;
    bus.in_data   = 8'(tr*N+tc);
    #1;
    if (bus.out_valid && !first_checked) begin
      first_checked = 1'b1;
      checks++;
      if (cyc != first_cyc+1) begin
        errors++;
        $display("FAIL first_latency got %0d exp %0d",
                 cyc-first_cyc, 1);
      end
    end
    exp_rdy = !bus.out_valid || ordy;
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready got %0b exp %0b", bus.in_ready, exp_rdy);
    end
    checks++;
    if (bus.lb_clk_en !== (v && exp_rdy)) begin
      errors++;
      $display("FAIL lb_clk_en got %0b exp %0b",
               bus.lb_clk_en, v && exp_rdy);
    end
    if (bus.out_valid && ordy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_window got %h exp none", bus.out_window);
      end else begin
        e = sb.pop_front();
        g.win  = bus.out_window;
        g.last = bus.out_last;
        if (g.win !== e.win || g.last !== e.last) begin
          errors++;
          $display("FAIL window got %h/%0b exp %h/%0b",
                   g.win, g.last, e.win, e.last);
        end
        wins++;
        if (g.last) lasts++;
      end
    end
    acc = v && exp_rdy;
    fdn = 1'b0;
    if (acc) begin
      accepts++;
      if (tr >= F-1 && tc >= F-1) begin
        for (int i = 0; i < F; i++)
          for (int j = 0; j < F; j++)
            e.win[(i*F+j)*DW +: DW] = 8'((tr-(F-1)+i)*N + tc-(F-1)+j);
        e.last = (tr == N-1 && tc == N-1);
        sb.push_back(e);
        if (first_cyc < 0) first_cyc = cyc;
      end
      fdn = (tr == N-1 && tc == N-1);
      ptr_m = (ptr_m+1) % DEPTH;
      if (tc == N-1) begin
        tc = 0;
        tr = (tr == N-1) ? 0 : tr+1;
      end else begin
        tc++;
      end
    end
    fd_exp = fdn;
  endtask

  task automatic run_pixels(input int n, input int gap_pct,
                            input int bp_pct);
    int target, guard;
    target = accepts + n;
    guard  = 0;
    while (accepts < target && guard < 5000) begin
      step($urandom_range(0, 99) >= gap_pct,
           $urandom_range(0, 99) >= bp_pct);
      guard++;
    end
    checks++;
    if (accepts < target) begin
      errors++;
      $display("FAIL pixel_budget got %0d exp %0d", accepts, target);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_windows got %0d exp 0", sb.size());
    end
  endtask

  task automatic check_count(input string nm, input int got,
                             input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp_v);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.lb_clk_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %0b/%0b exp 0/0",
               bus.in_ready, bus.lb_clk_en);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.out_window !== '0 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs got v%0b l%0b w%h fd%0b exp zeros",
               bus.out_valid, bus.out_last, bus.out_window,
               bus.frame_done);
    end
    checks++;
    if (bus.lb_wr_addr !== 3'd0 || bus.lb_rd_addr !== 3'd1) begin
      errors++;
      $display("FAIL rst_addr got %0d/%0d exp 0/1",
               bus.lb_wr_addr, bus.lb_rd_addr);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tr = 0; tc = 0; ptr_m = 0;
    fd_exp = 1'b0;
    first_cyc = -1;
    first_checked = 1'b0;
    sb.delete();
  endtask

  task automatic test_stream();
    wins = 0;
    run_pixels(N*N, 0, 0);
    drain();
    check_count("stream_windows", wins, (N-F+1)*(N-F+1));
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] held;
    wins = 0;
    run_pixels(2*N+F, 0, 0);
    step(1'b1, 1'b0);
    held = bus.out_window;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (bus.out_window !== held || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL held_window got %h exp %h", bus.out_window, held);
      end
    end
    run_pixels(N*N - (2*N+F), 0, 0);
    drain();
    check_count("bp_windows", wins, (N-F+1)*(N-F+1));
  endtask

  task automatic test_back_to_back();
    wins = 0;
    lasts = 0;
    run_pixels(2*N*N, 0, 0);
    drain();
    check_count("b2b_windows", wins, 2*(N-F+1)*(N-F+1));
    check_count("b2b_lasts", lasts, 2);
  endtask

  task automatic test_reset_mid();
    run_pixels(31, 0, 0);
    test_reset();
    wins = 0;
    run_pixels(N*N, 0, 0);
    drain();
    check_count("restart_windows", wins, (N-F+1)*(N-F+1));
  endtask

  task automatic test_gaps();
    wins = 0;
    lasts = 0;
    run_pixels(N*N, 40, 25);
    drain();
    check_count("gap_windows", wins, (N-F+1)*(N-F+1));
    check_count("gap_lasts", lasts, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    accepts = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < HL; k++) hist[k] = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
